vga_sync_gen: RTL and testbench

- VGA timing generator that produces hsync, vsync and the gated red/green/blue drive for the system's VGA pins.
- Sits between the CPU-side pixel/colour source (rgbinfo register or framebuffer read) and the board VGA outputs.
- Publishes the current pixel coordinate and a pixel-request strobe so upstream logic can supply colour one pixel ahead.
- Raises a latched frame interrupt at start of vertical blanking for game-loop timing.

---
 rtl/vga_sync_gen_if.sv | 26 ++
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Pixel-source / pin-side bundle of the VGA timing generator; the generator holds the master modport.
// Handshake: no valid/ready pair. pix_req is a one-cycle strobe and pix_rgb must be stable at that clock edge.
interface vga_sync_gen_if;
    logic [2:0] pix_rgb;
    logic       irq_ack;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_req;
    logic       active;
    logic       red;
    logic       green;
    logic       blue;
    logic       hsync;
    logic       vsync;
    logic       frame_irq;

    modport master (
        input  pix_rgb, irq_ack,
        output x, y, pix_req, active, red, green, blue, hsync, vsync, frame_irq
    );

    modport slave (
        output pix_rgb, irq_ack,
        input  x, y, pix_req, active, red, green, blue, hsync, vsync, frame_irq
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel strobe, x/y counters, registered sync/colour pins and a latched frame interrupt.
// Optional VGA_BORDER_EN paints the outermost visible pixels white.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [2:0] div_q, div_d;
    logic       pix_req_q, pix_req_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       active_q, active_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       irq_q, irq_d;
    logic       visible;
    logic [2:0] colour;

    assign visible = (x_q < X_VIS) && (y_q < Y_VIS);

`ifdef VGA_BORDER_EN
    localparam logic [9:0] X_EDGE = 10'(H_VISIBLE - 1);
    localparam logic [9:0] Y_EDGE = 10'(V_VISIBLE - 1);
    assign colour = ((x_q == 10'd0) || (x_q == X_EDGE) || (y_q == 10'd0) || (y_q == Y_EDGE))
                    ? 3'b111 : bus.pix_rgb;
`else
    assign colour = bus.pix_rgb;
`endif

    always_comb begin
        // pix_req is registered, so it mirrors the divider phase one clock late and rises on the first edge.
        div_d     = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
        pix_req_d = (div_q == 3'd0);
        x_d       = x_q;
        y_d       = y_q;
        active_d  = active_q;
        rgb_d     = rgb_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        if (pix_req_q) begin
            if (x_q == X_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
            active_d = visible;
            rgb_d    = visible ? colour : 3'b000;
            hsync_d  = ~((x_q >= HS_START) && (x_q < HS_END));
            vsync_d  = ~((y_q >= VS_START) && (y_q < VS_END));
        end
        // Set has priority over a coincident acknowledge.
        irq_d = irq_q;
        if (bus.irq_ack) irq_d = 1'b0;
        if (pix_req_q && (x_q == 10'd0) && (y_q == Y_VIS)) irq_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= 3'd0;
            pix_req_q <= 1'b0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            active_q  <= 1'b0;
            rgb_q     <= 3'b000;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            pix_req_q <= pix_req_d;
            x_q       <= x_d;
            y_q       <= y_d;
            active_q  <= active_d;
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.pix_req   = pix_req_q;
    assign bus.active    = active_q;
    assign bus.red       = rgb_q[2];
    assign bus.green     = rgb_q[1];
    assign bus.blue      = rgb_q[0];
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign bus.frame_irq = irq_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a shrunken raster so whole frames fit in a short run.
// Expected pins come from a closed-form cycle-count model and a per-pixel scoreboard queue.
module tb_vga_sync_gen;
    localparam int CLK_DIV   = 2;
    localparam int HV        = 16;
    localparam int HFP       = 2;
    localparam int HSY       = 3;
    localparam int HBP       = 3;
    localparam int VV        = 8;
    localparam int VFP       = 1;
    localparam int VSY       = 2;
    localparam int VBP       = 2;
    localparam int H_TOTAL   = HV + HFP + HSY + HBP;
    localparam int V_TOTAL   = VV + VFP + VSY + VBP;
    localparam int FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;
    localparam logic [5:0] RST_OUT = 6'b000011;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vga_sync_gen_if bus ();

    vga_sync_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [5:0] exp_q[$];
    logic [5:0] cur_out  = RST_OUT;
    int         n        = 0;
    bit         m_irq    = 1'b0;
    bit         pend_strobe = 1'b0;
    bit         pend_ack    = 1'b0;
    int         pend_x   = 0;
    int         pend_y   = 0;
    bit         cnt_en   = 1'b0;
    int         hs_low   = 0;
    int         vs_low   = 0;
    int         coinc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected {active, r, g, b, hsync, vsync} one pixel after pixel (px,py) is strobed.
    function automatic logic [5:0] model_out(input int px, input int py, input logic [2:0] rgb);
        bit         vis;
        bit         hs_on;
        bit         vs_on;
        logic [2:0] col;
        col   = rgb;
        vis   = (px < HV) && (py < VV);
`ifdef VGA_BORDER_EN
        if (px == 0 || px == HV - 1 || py == 0 || py == VV - 1) col = 3'b111;
`endif
        hs_on = (px >= HV + HFP) && (px < HV + HFP + HSY);
        vs_on = (py >= VV + VFP) && (py < VV + VFP + VSY);
        return {vis, (vis ? col : 3'b000), ~hs_on, ~vs_on};
    endfunction

    // Pixels consumed after k clock edges since reset release.
    function automatic int pix_count(input int k);
        return (k >= 2) ? (k - 2) / CLK_DIV + 1 : 0;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, 32'(bus.x), 32'd0);
        chk({tag, "_y"}, 32'(bus.y), 32'd0);
        chk({tag, "_pix_req"}, 32'(bus.pix_req), 32'd0);
        chk({tag, "_pins"}, 32'({bus.active, bus.red, bus.green, bus.blue, bus.hsync, bus.vsync}),
            32'(RST_OUT));
        chk({tag, "_irq"}, 32'(bus.frame_irq), 32'd0);
    endtask

    task automatic model_reset();
        n           = 0;
        m_irq       = 1'b0;
        cur_out     = RST_OUT;
        pend_strobe = 1'b0;
        pend_ack    = 1'b0;
        exp_q.delete();
    endtask

    // One clock: account for the edge just passed, compare every pin, then drive the next inputs.
    task automatic tick(input bit ack_req, input bit ack_at_set, input bit fixed_en,
                        input logic [2:0] fixed_rgb);
        int         cnt;
        int         ex;
        int         ey;
        bit         req;
        bit         ack;
        bit         at_set;
        bit         was_irq;
        logic [2:0] rgb;
        @(negedge clk);
        n++;
        was_irq = m_irq;
        if (pend_ack) m_irq = 1'b0;
        if (pend_strobe && pend_x == 0 && pend_y == VV) m_irq = 1'b1;
        if (pend_strobe) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) cur_out = exp_q.pop_front();
        end
        cnt = pix_count(n);
        ex  = cnt % H_TOTAL;
        ey  = (cnt / H_TOTAL) % V_TOTAL;
        req = (n >= 1) && ((n - 1) % CLK_DIV == 0);
        chk("x", 32'(bus.x), 32'(ex));
        chk("y", 32'(bus.y), 32'(ey));
        chk("pix_req", 32'(bus.pix_req), 32'(req));
        chk("active", 32'(bus.active), 32'(cur_out[5]));
        chk("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(cur_out[4:2]));
        chk("hsync", 32'(bus.hsync), 32'(cur_out[1]));
        chk("vsync", 32'(bus.vsync), 32'(cur_out[0]));
        chk("frame_irq", 32'(bus.frame_irq), 32'(m_irq));
        if (m_irq && !was_irq) begin
            chk("irq_set_y", 32'(bus.y), 32'(VV));
            chk("irq_set_x", 32'(bus.x), 32'd1);
        end
        if (cnt_en) begin
            if (!bus.hsync) hs_low++;
            if (!bus.vsync) vs_low++;
        end
        rgb    = fixed_en ? fixed_rgb : 3'($urandom_range(0, 7));
        at_set = req && ex == 0 && ey == VV;
        ack    = ack_req || (ack_at_set && at_set);
        if (ack_at_set && at_set) coinc++;
        bus.pix_rgb = rgb;
        bus.irq_ack = ack;
        pend_strobe = req;
        pend_x      = ex;
        pend_y      = ey;
        pend_ack    = ack;
        if (req) exp_q.push_back(model_out(ex, ey, rgb));
    endtask

    initial begin
        bus.pix_rgb = 3'b000;
        bus.irq_ack = 1'b0;

        // Power-on reset held for four clocks.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_reset("por");
        end
        rst = 1'b1;
        model_reset();

        // One full frame with constant colour 101: blanking gate and sync widths.
        cnt_en = 1'b1;
        for (int i = 0; i < FRAME_CLK; i++) tick(1'b0, 1'b0, 1'b1, 3'b101);
        cnt_en = 1'b0;
        chk("hsync_low_clks", 32'(hs_low), 32'(V_TOTAL * HSY * CLK_DIV));
        chk("vsync_low_clks", 32'(vs_low), 32'(VSY * H_TOTAL * CLK_DIV));
        chk("irq_after_frame", 32'(bus.frame_irq), 32'd1);

        // Acknowledge clears the latched interrupt on the next clock.
        tick(1'b1, 1'b0, 1'b0, 3'b000);
        tick(1'b0, 1'b0, 1'b0, 3'b000);
        chk("irq_cleared", 32'(bus.frame_irq), 32'd0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 3'b000);

        // Acknowledge landing on the exact set cycle: set must win.
        for (int i = 0; i < FRAME_CLK + 4; i++) tick(1'b0, 1'b1, 1'b0, 3'b000);
        chk("coincide_seen", 32'(coinc), 32'd1);
        chk("irq_set_wins", 32'(bus.frame_irq), 32'd1);

        // Another frame without acknowledge leaves it at 1.
        for (int i = 0; i < FRAME_CLK; i++) tick(1'b0, 1'b0, 1'b0, 3'b000);
        chk("irq_sticky", 32'(bus.frame_irq), 32'd1);

        // Asynchronous reset mid-frame, away from any clock edge.
        for (int i = 0; i < 37; i++) tick(1'b0, 1'b0, 1'b0, 3'b000);
        #2 rst = 1'b0;
        #1 chk_reset("mid_rst");
        @(negedge clk);
        chk_reset("mid_rst_hold");
        bus.irq_ack = 1'b0;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3 * H_TOTAL * CLK_DIV; i++) tick(1'b0, 1'b0, 1'b0, 3'b000);
        chk("no_partial_irq", 32'(bus.frame_irq), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
